top_or: RTL and testbench
=========================

Name: top_or

Overview:
- Two-input OR gate with a purely combinational result, plus a clocked monitor for that result.
- The monitor provides a registered copy, a debounced (filtered) copy, rise/fall pulses and a saturating high-time counter.
- Used as a basic logic leaf in small board designs. Monitor outputs are optional for users that wire only the three gate ports.

Parameters:
- CNT_W, 16, width of the high-time counter (>=1).
- FILT_LEN, 3, consecutive identical samples required before out0_filt changes (>=1).

Ports:
- clk  input  1  rising-edge clock for all registered logic.
- rst_n  input  1  synchronous active-low reset.
- in0  input  1  OR operand 0.
- in1  input  1  OR operand 1.
- out0  output  1  combinational in0 | in1.
- out0_q  output  1  out0 sampled on the previous clk edge.
- out0_filt  output  1  debounced out0.
- rise  output  1  one-cycle pulse on a sampled 0->1 transition.
- fall  output  1  one-cycle pulse on a sampled 1->0 transition.
- high_cnt  output  CNT_W  number of edges at which out0 was sampled high, saturating.
- cnt_sat  output  1  high_cnt is at its maximum.

Port declaration order is fixed as in0, in1, out0, clk, rst_n, then the remaining outputs. A positional three-port hookup (in0, in1, out0) must therefore work with clk and rst_n left unconnected.

Behaviour:
- One clock, clk; reset rst_n is synchronous and active-low.
- out0 = in0 | in1, zero latency.
  - Independent of clk and rst_n; valid with clk unconnected.
  - Either input at 1 forces out0 = 1.
- At each rising clk edge with rst_n=0:
  - out0_q, out0_filt, rise, fall, high_cnt, cnt_sat and the internal filter counter all become 0.
  - out0 is unaffected.
- At each rising clk edge with rst_n=1, let s be the sampled out0 and p the value of out0_q before the edge:
  - out0_q <= s. Latency is 1 edge.
  - rise <= s & ~p, and fall <= ~s & p. Each pulse lasts exactly one cycle.
  - The first sample after reset compares against p=0, so a high input at that edge gives rise=1.
  - Reset itself never produces a rise or fall pulse.
  - high_cnt increments by 1 when s=1, unless already at 2^CNT_W-1, where it holds.
  - cnt_sat = (high_cnt == 2^CNT_W-1), registered alongside high_cnt. Once set, it stays set until reset.
- Debounce filter (internal counter fc, ceil(log2(FILT_LEN+1)) bits):
  - If s == out0_filt: fc <= 0.
  - Otherwise fc increments. When fc+1 reaches FILT_LEN, out0_filt <= s and fc <= 0.
  - FILT_LEN=1 makes out0_filt equal to out0_q.
  - A mismatch run shorter than FILT_LEN leaves out0_filt unchanged.
- Simultaneous events: reset wins over every update at the same edge.
- Reset mid-operation: all registered state clears at that edge, and the monitor restarts from the power-up condition.
- No latches. All registered outputs are driven only from flops.

Test Plan:
- clk/rst_n unconnected: in0/in1 = 00, 10, 01, 11 at 10-unit steps -> out0 = 0, 1, 1, 1 immediately after each change.
- rst_n=0 for 2 edges with in0=1 -> out0=1; out0_q, out0_filt, rise, fall, high_cnt, cnt_sat all 0; first edge after release -> out0_q=1, rise=1.
- After reset, inputs 00 for 2 edges, then in1=1 for 3 edges, then 00 -> rise high for exactly 1 cycle, out0_q follows 1 edge late, fall high for 1 cycle, high_cnt=3.
- FILT_LEN=3: out0 high for 2 edges then low -> out0_filt stays 0; out0 high for 3 edges -> out0_filt=1 after the 3rd edge.
- CNT_W=4: in0=1 held for 20 edges -> high_cnt stops at 15, cnt_sat=1 from that edge onward, no wrap to 0.
- Mid-operation reset with high_cnt=7 and out0_filt=1 -> all registered outputs 0 the next cycle, no rise/fall pulse, out0 still tracks in0|in1.

Source files
------------

// File: rtl/top_or.sv
// Two-input OR gate with a clocked monitor of its result: registered copy,
// debounced copy, edge pulses and a saturating high-time counter.
module top_or #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic             in0,
  input  logic             in1,
  output logic             out0,
  input  logic             clk,
  input  logic             rst_n,
  output logic             out0_q,
  output logic             out0_filt,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] high_cnt,
  output logic             cnt_sat
);

  localparam int unsigned       FC_W     = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0]   FC_ONE   = FC_W'(1);
  localparam logic [FC_W-1:0]   FC_LIMIT = FC_W'(FILT_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [FC_W-1:0]  fc;
  logic [CNT_W-1:0] cnt_nxt;

  assign out0 = in0 | in1;

  always_comb begin
    cnt_nxt = high_cnt;
    if (out0 && (high_cnt != CNT_MAX))
      cnt_nxt = high_cnt + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0_q    <= 1'b0;
      out0_filt <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      high_cnt  <= '0;
      cnt_sat   <= 1'b0;
      fc        <= '0;
    end else begin
      out0_q   <= out0;
      rise     <= out0 & ~out0_q;
      fall     <= ~out0 & out0_q;
      high_cnt <= cnt_nxt;
      // Flag follows the next count value so it lines up with high_cnt.
      cnt_sat  <= (cnt_nxt == CNT_MAX);
      if (out0 == out0_filt) begin
        fc <= '0;
      end else if ((fc + FC_ONE) == FC_LIMIT) begin
        out0_filt <= out0;
        fc        <= '0;
      end else begin
        fc <= fc + FC_ONE;
      end
    end
  end

endmodule

// File: tb/tb_top_or.sv
// Randomized and directed bench for top_or, checked against a behavioural
// model built from run lengths and saturating integer counts.
module tb_top_or;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;
  logic in0 = 1'b0;
  logic in1 = 1'b0;

  logic       out0, q0, filt0, rise0, fall0, sat0;
  logic [3:0] cnt0;
  logic       out1, q1, filt1, rise1, fall1, sat1;
  logic [15:0] cnt1;

  int total = 0;
  int bad   = 0;

  // model state
  int m_q, m_rise, m_fall;
  int m_filt [2];
  int m_run  [2];
  int m_cnt  [2];
  int m_sat  [2];
  int flen   [2] = '{3, 1};
  int cmax   [2] = '{15, 65535};

  top_or #(.CNT_W(4), .FILT_LEN(3)) u0 (
    .in0(in0), .in1(in1), .out0(out0), .clk(clk), .rst_n(rst_n),
    .out0_q(q0), .out0_filt(filt0), .rise(rise0), .fall(fall0),
    .high_cnt(cnt0), .cnt_sat(sat0)
  );

  top_or #(.CNT_W(16), .FILT_LEN(1)) u1 (
    .in0(in0), .in1(in1), .out0(out1), .clk(clk), .rst_n(rst_n),
    .out0_q(q1), .out0_filt(filt1), .rise(rise1), .fall(fall1),
    .high_cnt(cnt1), .cnt_sat(sat1)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rise = 0; m_fall = 0;
    for (int k = 0; k < 2; k++) begin
      m_filt[k] = 0; m_run[k] = 0; m_cnt[k] = 0; m_sat[k] = 0;
    end
  endtask

  task automatic model_edge();
    int s;
    s = (in0 || in1) ? 1 : 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_rise = (s == 1 && m_q == 0) ? 1 : 0;
      m_fall = (s == 0 && m_q == 1) ? 1 : 0;
      m_q = s;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = (m_cnt[k] + s > cmax[k]) ? cmax[k] : m_cnt[k] + s;
        m_sat[k] = (m_cnt[k] == cmax[k]) ? 1 : 0;
        if (s == m_filt[k]) begin
          m_run[k] = 0;
        end else begin
          m_run[k]++;
          if (m_run[k] == flen[k]) begin
            m_filt[k] = s;
            m_run[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("q0", q0, m_q);
    chk("rise0", rise0, m_rise);
    chk("fall0", fall0, m_fall);
    chk("filt0", filt0, m_filt[0]);
    chk("cnt0", cnt0, m_cnt[0]);
    chk("sat0", sat0, m_sat[0]);
    chk("q1", q1, m_q);
    chk("filt1", filt1, m_filt[1]);
    chk("cnt1", cnt1, m_cnt[1]);
    chk("sat1", sat1, m_sat[1]);
  endtask

  task automatic tick(input logic a, input logic b, input logic rn);
    @(negedge clk);
    in0 = a; in1 = b; rst_n = rn;
    #1;
    chk("out0", out0, a | b);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic [1:0] pat;
    // combinational path before any clock activity
    for (int i = 0; i < 4; i++) begin
      pat = i[1:0];
      in0 = pat[0]; in1 = pat[1];
      #1;
      chk("comb_out0", out0, pat[0] | pat[1]);
      chk("comb_out1", out1, pat[0] | pat[1]);
      #9;
    end
    clk_en = 1'b1;

    // reset held two edges with in0 high
    model_reset();
    tick(1, 0, 0);
    tick(1, 0, 0);
    chk("rst_out0", out0, 1);
    chk("rst_q", q0, 0);
    chk("rst_cnt", cnt0, 0);
    tick(1, 0, 1);
    chk("first_rise", rise0, 1);
    chk("first_q", q0, 1);

    // pulse widths and count after a fresh reset
    tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 1, 1);
    tick(0, 0, 1);
    chk("dir_cnt3", cnt0, 3);
    chk("dir_fall", fall0, 1);
    tick(0, 0, 1);
    chk("dir_fall_end", fall0, 0);

    // short glitch must not reach the filter, a 3-edge run must
    tick(0, 0, 1);
    tick(1, 0, 1);
    tick(1, 0, 1);
    tick(0, 0, 1);
    chk("filt_short", filt0, 0);
    tick(1, 0, 1);
    tick(1, 0, 1);
    chk("filt_pending", filt0, 0);
    tick(1, 0, 1);
    chk("filt_set", filt0, 1);

    // saturation of the 4-bit counter
    tick(0, 0, 0);
    for (int i = 0; i < 20; i++) tick(1, 0, 1);
    chk("sat_cnt", cnt0, 15);
    chk("sat_flag", sat0, 1);

    // mid-operation reset with count 7 and filter set
    tick(0, 0, 0);
    for (int i = 0; i < 7; i++) tick(0, 1, 1);
    chk("mid_cnt7", cnt0, 7);
    chk("mid_filt", filt0, 1);
    tick(1, 1, 0);
    chk("mid_rst_cnt", cnt0, 0);
    chk("mid_rst_rise", rise0, 0);
    chk("mid_rst_fall", fall0, 0);
    chk("mid_rst_out0", out0, 1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic a, b, rn;
      a  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 3) == 0);
      rn = ($urandom_range(0, 39) != 0);
      tick(a, b, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
